pipeline_stall_controller: RTL and testbench

- Produces the stall, bubble and flush controls for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It complements operand forwarding.
- Handles the hazards forwarding cannot resolve: load-use dependencies, outstanding I-cache and D-cache accesses, and taken-branch redirects.
- Drives the per-stage register load enables and flush (insert-NOP) controls.
- Keeps performance counters and a stall watchdog for debug.

---
 rtl/rv32i_types.sv | 67 ++++++
 rtl/load_use_detector.sv | 25 ++
 rtl/pipeline_stall_controller.sv | 156 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index, stall-controller state and
// the bundle of per-stage load/flush controls with its canonical encodings.
package rv32i_types;

  // Architectural register index (x0..x31).
  typedef logic [4:0] rv32i_reg;

  // Stall controller state, reported for debug and tracked per cycle.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DSTALL  = 2'd1,
    ISTALL  = 2'd2,
    BR_WAIT = 2'd3
  } pipe_ctrl_state_t;

  // Per-stage pipeline register controls. A flush bit only has effect
  // when the matching load bit is also set (the register loads a NOP).
  typedef struct packed {
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
    logic load_memwb;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
  } pipe_ctrl_t;

  // Everything held, nothing squashed (reset and D-side freeze).
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b0, load_exmem: 1'b0,
    load_memwb: 1'b0, flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0
  };

  // Branch held in EX while the I-side refetch is outstanding: a bubble
  // goes into EX/MEM so the branch is not committed twice.
  localparam pipe_ctrl_t CTRL_BR_HOLD = '{
    load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b0, load_exmem: 1'b1,
    load_memwb: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b1
  };

  // Redirect: everything advances, the two wrong-path slots are squashed.
  localparam pipe_ctrl_t CTRL_REDIRECT = '{
    load_pc: 1'b1, load_ifid: 1'b1, load_idex: 1'b1, load_exmem: 1'b1,
    load_memwb: 1'b1, flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b0
  };

  // Front end held, a bubble is injected into EX, the back end drains.
  // Shared by the I-miss stall and the load-use stall.
  localparam pipe_ctrl_t CTRL_FRONT_HOLD = '{
    load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b1, load_exmem: 1'b1,
    load_memwb: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b1, flush_exmem: 1'b0
  };

  // Normal flow.
  localparam pipe_ctrl_t CTRL_RUN = '{
    load_pc: 1'b1, load_ifid: 1'b1, load_idex: 1'b1, load_exmem: 1'b1,
    load_memwb: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0
  };

  // True when a source register matches a nonzero destination.
  function automatic logic reg_hit(input rv32i_reg src, input logic use_src,
                                   input rv32i_reg dst);
    return use_src && (src == dst) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection: the instruction in ID reads a
// register that the load currently in EX has not yet produced.
module load_use_detector
  import rv32i_types::*;
(
  input  rv32i_reg i_ifid_rs1,
  input  rv32i_reg i_ifid_rs2,
  input  logic     i_ifid_use_rs1,
  input  logic     i_ifid_use_rs2,
  input  rv32i_reg i_idex_rd,
  input  logic     i_idex_mem_read,
  output logic     o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  // x0 never creates a dependency, so a load targeting x0 never stalls.
  always_comb begin
    w_hit_rs1  = reg_hit(i_ifid_rs1, i_ifid_use_rs1, i_idex_rd);
    w_hit_rs2  = reg_hit(i_ifid_rs2, i_ifid_use_rs2, i_idex_rd);
    o_load_use = i_idex_mem_read && (w_hit_rs1 || w_hit_rs2);
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall / bubble / flush control for the 5-stage RV32I pipeline, plus
// stall and flush performance counters and a sticky stall watchdog.
module pipeline_stall_controller
  import rv32i_types::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_reg         IFID_rs1,
  input  rv32i_reg         IFID_rs2,
  input  logic             IFID_use_rs1,
  input  logic             IFID_use_rs2,
  input  rv32i_reg         IDEX_rd,
  input  logic             IDEX_mem_read,
  input  logic             br_taken,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic             dcache_read,
  input  logic             dcache_write,
  input  logic             dcache_resp,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output pipe_ctrl_state_t state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  localparam logic [TO_W-1:0] TIMEOUT_LIM = TO_W'(TIMEOUT);

  logic             w_dmem_busy;
  logic             w_imem_busy;
  logic             w_load_use;
  pipe_ctrl_t       w_ctrl;
  pipe_ctrl_state_t w_state_next;
  pipe_ctrl_state_t r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [TO_W-1:0]  r_consec;
  logic [TO_W-1:0]  w_consec_next;
  logic             r_timeout;

  load_use_detector u_load_use (
    .i_ifid_rs1      (IFID_rs1),
    .i_ifid_rs2      (IFID_rs2),
    .i_ifid_use_rs1  (IFID_use_rs1),
    .i_ifid_use_rs2  (IFID_use_rs2),
    .i_idex_rd       (IDEX_rd),
    .i_idex_mem_read (IDEX_mem_read),
    .o_load_use      (w_load_use)
  );

  // Outstanding memory accesses; a response in the same cycle releases.
  always_comb begin
    w_dmem_busy = (dcache_read || dcache_write) && !dcache_resp;
    w_imem_busy = icache_read && !icache_resp;
  end

  // Hazard priority encoder. The controls depend only on the current
  // inputs: a branch held in EX keeps br_taken asserted, so BR_WAIT and
  // DSTALL re-evaluate naturally each cycle without extra state.
  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_state_next = RUN;
    if (rst) begin
      w_ctrl       = CTRL_FREEZE;
      w_state_next = RUN;
    end else if (w_dmem_busy) begin
      w_ctrl       = CTRL_FREEZE;
      w_state_next = DSTALL;
    end else if (br_taken && w_imem_busy) begin
      w_ctrl       = CTRL_BR_HOLD;
      w_state_next = BR_WAIT;
    end else if (br_taken) begin
      // Outranks load-use: the dependent ID instruction is squashed anyway.
      w_ctrl       = CTRL_REDIRECT;
      w_state_next = RUN;
    end else if (w_imem_busy) begin
      w_ctrl       = CTRL_FRONT_HOLD;
      w_state_next = ISTALL;
    end else if (w_load_use) begin
      // The injected bubble clears the hazard next cycle: one stall only.
      w_ctrl       = CTRL_FRONT_HOLD;
      w_state_next = RUN;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Consecutive-stall count, saturating at the watchdog limit.
  always_comb begin
    w_consec_next = '0;
    if (!w_ctrl.load_pc) begin
      if (r_consec >= TIMEOUT_LIM) begin
        w_consec_next = TIMEOUT_LIM;
      end else begin
        w_consec_next = r_consec + TO_W'(1);
      end
    end
  end

  // Performance counters (free-running, wrap) and the sticky watchdog.
  // The flag sets on the same edge the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_consec    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (!w_ctrl.load_pc) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_ctrl.flush_ifid) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      r_consec <= w_consec_next;
      if (w_consec_next >= TIMEOUT_LIM) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Output mapping.
  always_comb begin
    load_pc       = w_ctrl.load_pc;
    load_ifid     = w_ctrl.load_ifid;
    load_idex     = w_ctrl.load_idex;
    load_exmem    = w_ctrl.load_exmem;
    load_memwb    = w_ctrl.load_memwb;
    flush_ifid    = w_ctrl.flush_ifid;
    flush_idex    = w_ctrl.flush_idex;
    flush_exmem   = w_ctrl.flush_exmem;
    state         = r_state;
    stall_cnt     = r_stall_cnt;
    flush_cnt     = r_flush_cnt;
    stall_timeout = r_timeout;
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed hazard
// scenarios followed by randomized traffic, compared cycle by cycle
// against a rule-level reference model.
module tb_pipeline_stall_controller;
  import rv32i_types::*;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;

  logic clk = 1'b0;
  logic rst;
  rv32i_reg IFID_rs1, IFID_rs2, IDEX_rd;
  logic IFID_use_rs1, IFID_use_rs2, IDEX_mem_read, br_taken;
  logic icache_read, icache_resp, dcache_read, dcache_write, dcache_resp;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic flush_ifid, flush_idex, flush_exmem;
  pipe_ctrl_state_t state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic stall_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;

  // Reference model state (plain integers).
  int m_state  = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  int m_consec = 0;
  int m_to     = 0;

  pipeline_stall_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_mem_read(IDEX_mem_read),
    .br_taken(br_taken),
    .icache_read(icache_read), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_resp(dcache_resp),
    .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0;
    IDEX_rd = 5'd0; IDEX_mem_read = 1'b0; br_taken = 1'b0;
    icache_read = 1'b0; icache_resp = 1'b0;
    dcache_read = 1'b0; dcache_write = 1'b0; dcache_resp = 1'b0;
  endtask

  // Expected controls {load_pc,ifid,idex,exmem,memwb,flush_ifid,idex,exmem}
  // and next state, straight from the hazard rules.
  task automatic model(output logic [7:0] ctrl, output int nstate);
    bit dbusy, ibusy, lu;
    dbusy = (dcache_read || dcache_write) && !dcache_resp;
    ibusy = icache_read && !icache_resp;
    lu = IDEX_mem_read && IDEX_rd != 0 &&
         ((IDEX_rd == IFID_rs1 && IFID_use_rs1) || (IDEX_rd == IFID_rs2 && IFID_use_rs2));
    if (rst)                  begin ctrl = 8'b00000000; nstate = 0; end
    else if (dbusy)           begin ctrl = 8'b00000000; nstate = 1; end
    else if (br_taken && ibusy) begin ctrl = 8'b00011001; nstate = 3; end
    else if (br_taken)        begin ctrl = 8'b11111110; nstate = 0; end
    else if (ibusy)           begin ctrl = 8'b00111010; nstate = 2; end
    else if (lu)              begin ctrl = 8'b00111010; nstate = 0; end
    else                      begin ctrl = 8'b11111000; nstate = 0; end
  endtask

  // One clock cycle: inputs already driven just after the previous edge.
  task automatic step(input string name);
    logic [7:0] e_ctrl;
    logic [7:0] g_ctrl;
    int e_state;
    #2;
    model(e_ctrl, e_state);
    g_ctrl = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
              flush_ifid, flush_idex, flush_exmem};
    check({name, ".ctrl"}, {24'd0, g_ctrl}, {24'd0, e_ctrl});
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_to = 0;
    end else begin
      m_state = e_state;
      if (!e_ctrl[7]) m_stall = (m_stall + 1) % (1 << CNT_W);
      if (e_ctrl[2])  m_flush = (m_flush + 1) % (1 << CNT_W);
      if (e_ctrl[7]) m_consec = 0;
      else if (m_consec < TIMEOUT) m_consec++;
      if (m_consec >= TIMEOUT) m_to = 1;
    end
    @(posedge clk);
    #1;
    n_cyc++;
    check({name, ".state"}, {30'd0, state}, 32'(m_state));
    check({name, ".stall_cnt"}, {24'd0, stall_cnt}, 32'(m_stall));
    check({name, ".flush_cnt"}, {24'd0, flush_cnt}, 32'(m_flush));
    check({name, ".timeout"}, {31'd0, stall_timeout}, 32'(m_to));
    $display("cyc %0d %s ctrl=%b state=%0d stall=%0d flush=%0d to=%0b",
             n_cyc, name, g_ctrl, state, stall_cnt, flush_cnt, stall_timeout);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step("reset"); rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Load-use: one stall, then the bubble removes the hazard.
    idle(); IDEX_mem_read = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd5; IFID_use_rs1 = 1'b1;
    step("lu");
    IDEX_mem_read = 1'b0; IDEX_rd = 5'd0;
    step("lu_bubble");
    check("lu_single_stall", {24'd0, stall_cnt}, 32'd1);
    idle(); IDEX_mem_read = 1'b1; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_use_rs1 = 1'b1;
    step("lu_x0");

    // D-miss: three frozen cycles, released on the response.
    do_reset();
    idle(); dcache_read = 1'b1;
    repeat (3) step("dmiss");
    dcache_resp = 1'b1;
    step("dmiss_resp");
    check("dmiss_stalls", {24'd0, stall_cnt}, 32'd3);

    // Taken branch, no miss.
    do_reset();
    idle(); br_taken = 1'b1; step("br");
    check("br_flushes", {24'd0, flush_cnt}, 32'd1);

    // Taken branch during an I-miss.
    idle(); br_taken = 1'b1; icache_read = 1'b1;
    repeat (2) step("br_imiss");
    icache_resp = 1'b1; step("br_imiss_resp");

    // Priority: D freeze over branch over load-use.
    idle(); dcache_write = 1'b1; br_taken = 1'b1;
    IDEX_mem_read = 1'b1; IDEX_rd = 5'd7; IFID_rs2 = 5'd7; IFID_use_rs2 = 1'b1;
    repeat (2) step("prio_freeze");
    dcache_resp = 1'b1; icache_read = 1'b1; icache_resp = 1'b1;
    step("prio_release");

    // Watchdog: ten I-miss cycles with TIMEOUT=8, then reset clears it.
    do_reset();
    idle(); icache_read = 1'b1;
    repeat (10) step("wd");
    check("wd_sticky", {31'd0, stall_timeout}, 32'd1);
    do_reset();
    check("wd_cleared", {31'd0, stall_timeout}, 32'd0);

    // Randomized traffic with a small register set to provoke hazards.
    for (int i = 0; i < 700; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      IFID_rs1      = 5'($urandom_range(0, 3));
      IFID_rs2      = 5'($urandom_range(0, 3));
      IFID_use_rs1  = 1'($urandom_range(0, 1));
      IFID_use_rs2  = 1'($urandom_range(0, 1));
      IDEX_rd       = 5'($urandom_range(0, 3));
      IDEX_mem_read = 1'($urandom_range(0, 1));
      br_taken      = ($urandom_range(0, 4) == 0);
      icache_read   = ($urandom_range(0, 2) != 0);
      icache_resp   = ($urandom_range(0, 2) == 0);
      dcache_read   = ($urandom_range(0, 4) == 0);
      dcache_write  = ($urandom_range(0, 6) == 0);
      dcache_resp   = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
